// File: rtl/mag_comp_min2_search_ctrl_if.sv
// rtl/mag_comp_min2_search_ctrl_if.sv - control/sample/result bundle for the two-minimum search block
interface mag_comp_min2_search_ctrl_if #(
  parameter int IDX_WIDTH = 8
);
  logic                 i_start;
  logic                 i_abort;
  logic                 i_valid;
  logic [2:0]           i_val;
  logic                 o_ready;
  logic                 o_busy;
  logic                 o_done;
  logic [2:0]           o_min1_val;
  logic [IDX_WIDTH-1:0] o_min1_idx;
  logic [2:0]           o_min2_val;
  logic [IDX_WIDTH-1:0] o_min2_idx;

  modport master (
    output i_start, i_abort, i_valid, i_val,
    input  o_ready, o_busy, o_done, o_min1_val, o_min1_idx, o_min2_val, o_min2_idx
  );

  modport slave (
    input  i_start, i_abort, i_valid, i_val,
    output o_ready, o_busy, o_done, o_min1_val, o_min1_idx, o_min2_val, o_min2_idx
  );
endinterface

// File: rtl/mag_comp_min2_search_ctrl.sv
// rtl/mag_comp_min2_search_ctrl.sv - streams 3-bit reliabilities and tracks the two smallest with indices
module mag_comp_min2_search_ctrl #(
  parameter int IDX_WIDTH = 8,
  parameter int FRAME_LEN = 255
) (
  input  logic                          clk,
  input  logic                          rstn,
  mag_comp_min2_search_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(FRAME_LEN - 1);
  localparam logic [IDX_WIDTH-1:0] IDX_ONES = {IDX_WIDTH{1'b1}};
  localparam logic [IDX_WIDTH-1:0] IDX_ZERO = '0;
  localparam logic [IDX_WIDTH-1:0] IDX_ONE  = IDX_WIDTH'(1);

  state_t               state_q, state_d;
  logic [IDX_WIDTH-1:0] cnt_q, cnt_d;
  logic [2:0]           min1_val_q, min1_val_d;
  logic [IDX_WIDTH-1:0] min1_idx_q, min1_idx_d;
  logic [2:0]           min2_val_q, min2_val_d;
  logic [IDX_WIDTH-1:0] min2_idx_q, min2_idx_d;
  logic                 done_q, done_d;

  // Next-state and datapath: one strict less-than compare chain per accepted sample
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    min1_val_d = min1_val_q;
    min1_idx_d = min1_idx_q;
    min2_val_d = min2_val_q;
    min2_idx_d = min2_idx_q;
    done_d     = 1'b0;

    if (bus.i_abort) begin
      // Abort wins over start and valid; results are discarded, no done pulse
      state_d    = ST_IDLE;
      cnt_d      = '0;
      min1_val_d = 3'b111;
      min1_idx_d = IDX_ONES;
      min2_val_d = 3'b111;
      min2_idx_d = IDX_ONES;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bus.i_start) begin
            state_d    = ST_RUN;
            cnt_d      = '0;
            min1_val_d = 3'b111;
            min1_idx_d = IDX_ONES;
            min2_val_d = 3'b111;
            min2_idx_d = IDX_ONES;
          end
        end
        ST_RUN: begin
          if (bus.i_valid) begin
            if (cnt_q == IDX_ZERO) begin
              // First sample always seeds min1, even if it equals the reset value
              min1_val_d = bus.i_val;
              min1_idx_d = cnt_q;
            end else if (bus.i_val < min1_val_q) begin
              min2_val_d = min1_val_q;
              min2_idx_d = min1_idx_q;
              min1_val_d = bus.i_val;
              min1_idx_d = cnt_q;
            end else if ((cnt_q == IDX_ONE) || (bus.i_val < min2_val_q)) begin
              // Second sample always seeds min2 so a tie with min1 keeps index 1
              min2_val_d = bus.i_val;
              min2_idx_d = cnt_q;
            end

            if (cnt_q == LAST_IDX) begin
              // Counter is held on the last index so full-range frames never wrap
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              cnt_d = cnt_q + IDX_ONE;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and result registers with asynchronous reset
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      min1_val_q <= 3'b111;
      min1_idx_q <= IDX_ONES;
      min2_val_q <= 3'b111;
      min2_idx_q <= IDX_ONES;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      min1_val_q <= min1_val_d;
      min1_idx_q <= min1_idx_d;
      min2_val_q <= min2_val_d;
      min2_idx_q <= min2_idx_d;
      done_q     <= done_d;
    end
  end

  assign bus.o_ready    = (state_q == ST_RUN);
  assign bus.o_busy     = (state_q == ST_RUN);
  assign bus.o_done     = done_q;
  assign bus.o_min1_val = min1_val_q;
  assign bus.o_min1_idx = min1_idx_q;
  assign bus.o_min2_val = min2_val_q;
  assign bus.o_min2_idx = min2_idx_q;

endmodule

// File: tb/tb_mag_comp_min2_search_ctrl.sv
// tb/tb_mag_comp_min2_search_ctrl.sv - scoreboard bench for the two-minimum search block
`timescale 1ns/1ps
module tb_mag_comp_min2_search_ctrl;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  // Shared sample/abort inputs; each DUT has its own start so only one runs a frame
  logic [2:0] start_v = '0;
  logic       abort = 1'b0;
  logic       valid = 1'b0;
  logic [2:0] val = '0;

  mag_comp_min2_search_ctrl_if #(.IDX_WIDTH(8)) if6 ();
  mag_comp_min2_search_ctrl_if #(.IDX_WIDTH(8)) if4 ();
  mag_comp_min2_search_ctrl_if #(.IDX_WIDTH(8)) if256 ();

  assign if6.i_start   = start_v[0];
  assign if4.i_start   = start_v[1];
  assign if256.i_start = start_v[2];
  assign if6.i_abort   = abort;
  assign if4.i_abort   = abort;
  assign if256.i_abort = abort;
  assign if6.i_valid   = valid;
  assign if4.i_valid   = valid;
  assign if256.i_valid = valid;
  assign if6.i_val     = val;
  assign if4.i_val     = val;
  assign if256.i_val   = val;

  mag_comp_min2_search_ctrl #(.IDX_WIDTH(8), .FRAME_LEN(6))   dut6   (.clk(clk), .rstn(rstn), .bus(if6));
  mag_comp_min2_search_ctrl #(.IDX_WIDTH(8), .FRAME_LEN(4))   dut4   (.clk(clk), .rstn(rstn), .bus(if4));
  mag_comp_min2_search_ctrl #(.IDX_WIDTH(8), .FRAME_LEN(256)) dut256 (.clk(clk), .rstn(rstn), .bus(if256));

  logic       o_ready [3];
  logic       o_busy  [3];
  logic       o_done  [3];
  logic [2:0] o_v1    [3];
  logic [7:0] o_i1    [3];
  logic [2:0] o_v2    [3];
  logic [7:0] o_i2    [3];

  assign o_ready[0] = if6.o_ready;   assign o_ready[1] = if4.o_ready;   assign o_ready[2] = if256.o_ready;
  assign o_busy[0]  = if6.o_busy;    assign o_busy[1]  = if4.o_busy;    assign o_busy[2]  = if256.o_busy;
  assign o_done[0]  = if6.o_done;    assign o_done[1]  = if4.o_done;    assign o_done[2]  = if256.o_done;
  assign o_v1[0]    = if6.o_min1_val; assign o_v1[1]   = if4.o_min1_val; assign o_v1[2]   = if256.o_min1_val;
  assign o_i1[0]    = if6.o_min1_idx; assign o_i1[1]   = if4.o_min1_idx; assign o_i1[2]   = if256.o_min1_idx;
  assign o_v2[0]    = if6.o_min2_val; assign o_v2[1]   = if4.o_min2_val; assign o_v2[2]   = if256.o_min2_val;
  assign o_i2[0]    = if6.o_min2_idx; assign o_i2[1]   = if4.o_min2_idx; assign o_i2[2]   = if256.o_min2_idx;

  typedef struct {
    logic [2:0] v1;
    logic [7:0] i1;
    logic [2:0] v2;
    logic [7:0] i2;
  } exp_t;

  exp_t sb[$];
  int   fv[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference: min1 is the lowest-index minimum; min2 is the lowest-index minimum of the rest
  task automatic push_expected();
    exp_t e;
    int   b1, b2;
    b1 = 0;
    for (int i = 1; i < fv.size(); i++) if (fv[i] < fv[b1]) b1 = i;
    b2 = -1;
    for (int i = 0; i < fv.size(); i++)
      if (i != b1 && (b2 < 0 || fv[i] < fv[b2])) b2 = i;
    e.v1 = 3'(fv[b1]); e.i1 = 8'(b1);
    e.v2 = 3'(fv[b2]); e.i2 = 8'(b2);
    sb.push_back(e);
  endtask

  // Drive fv through DUT sel; optional idle gap between samples and a start pulse in RUN
  task automatic run_frame(input int sel, input int gap, input bit mid_start, input string name);
    exp_t e;
    push_expected();
    start_v[sel] = 1'b1;
    @(negedge clk);
    start_v[sel] = 1'b0;
    n_cmp++;
    if (o_busy[sel] !== 1'b1) begin
      n_bad++; $display("FAIL %s busy_after_start got=%0b exp=1", name, o_busy[sel]);
    end
    for (int k = 0; k < fv.size(); k++) begin
      n_cmp++;
      if (o_ready[sel] !== 1'b1 || o_done[sel] !== 1'b0) begin
        n_bad++; $display("FAIL %s ready_in_run k=%0d ready=%0b done=%0b exp ready=1 done=0", name, k, o_ready[sel], o_done[sel]);
      end
      valid = 1'b1;
      val   = 3'(fv[k]);
      @(negedge clk);
      valid = 1'b0;
      val   = 3'($urandom_range(0, 7));
      if (k != fv.size() - 1) begin
        for (int g = 0; g < gap; g++) begin
          if (mid_start && k == 1 && g == 0) start_v[sel] = 1'b1;
          @(negedge clk);
          start_v[sel] = 1'b0;
          n_cmp++;
          if (o_done[sel] !== 1'b0) begin
            n_bad++; $display("FAIL %s early_done k=%0d got=%0b exp=0", name, k, o_done[sel]);
          end
        end
      end
    end
    n_cmp++;
    if (o_done[sel] !== 1'b1 || o_ready[sel] !== 1'b0) begin
      n_bad++; $display("FAIL %s done_latency done=%0b ready=%0b exp done=1 ready=0", name, o_done[sel], o_ready[sel]);
    end
    if (sb.size() == 0) begin
      n_cmp++; n_bad++; $display("FAIL %s scoreboard_empty got=0 exp=1", name);
    end else begin
      e = sb.pop_front();
      n_cmp++;
      if (o_v1[sel] !== e.v1 || o_i1[sel] !== e.i1 || o_v2[sel] !== e.v2 || o_i2[sel] !== e.i2) begin
        n_bad++;
        $display("FAIL %s results got min1=(%0d,%0d) min2=(%0d,%0d) exp min1=(%0d,%0d) min2=(%0d,%0d)",
                 name, o_v1[sel], o_i1[sel], o_v2[sel], o_i2[sel], e.v1, e.i1, e.v2, e.i2);
      end
    end
    // Results held and done only one cycle wide, even with i_valid present
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    n_cmp++;
    if (o_done[sel] !== 1'b0 || o_busy[sel] !== 1'b0) begin
      n_bad++; $display("FAIL %s done_width done=%0b busy=%0b exp 0 0", name, o_done[sel], o_busy[sel]);
    end
  endtask

  task automatic check_reset_vals(input int sel, input string name);
    n_cmp++;
    if (o_v1[sel] !== 3'd7 || o_v2[sel] !== 3'd7 || o_i1[sel] !== 8'hFF || o_i2[sel] !== 8'hFF) begin
      n_bad++; $display("FAIL %s min_regs got v1=%0d i1=%0h v2=%0d i2=%0h exp 7 ff 7 ff", name, o_v1[sel], o_i1[sel], o_v2[sel], o_i2[sel]);
    end
    n_cmp++;
    if (o_done[sel] !== 1'b0 || o_ready[sel] !== 1'b0 || o_busy[sel] !== 1'b0) begin
      n_bad++; $display("FAIL %s ctrl got done=%0b ready=%0b busy=%0b exp 0 0 0", name, o_done[sel], o_ready[sel], o_busy[sel]);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals(0, "reset_initial");
    rstn = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    valid = 1'b1; val = 3'd1;
    repeat (2) @(negedge clk);
    valid = 1'b0;
    #2 rstn = 1'b0;
    #1 check_reset_vals(0, "reset_mid_frame");
    @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_vals(0, "reset_no_report");
  endtask

  task automatic test_basic();
    fv = '{5, 2, 6, 1, 4, 3};
    run_frame(0, 0, 1'b0, "basic");
  endtask

  task automatic test_ties();
    fv = '{3, 3, 3, 3};
    run_frame(1, 0, 1'b0, "ties_equal");
    fv = '{4, 2, 2, 0};
    run_frame(1, 0, 1'b0, "ties_mixed");
  endtask

  task automatic test_gapped();
    fv = '{7, 0, 7, 1};
    run_frame(1, 2, 1'b1, "gapped_start");
  endtask

  task automatic test_abort();
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    valid = 1'b1; val = 3'd0;
    @(negedge clk);
    val = 3'd1;
    @(negedge clk);
    abort = 1'b1; start_v[0] = 1'b1;
    @(negedge clk);
    abort = 1'b0; start_v[0] = 1'b0;
    check_reset_vals(0, "abort_idle");
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_cmp++;
      if (o_done[0] !== 1'b0 || o_busy[0] !== 1'b0) begin
        n_bad++; $display("FAIL abort_no_done c=%0d done=%0b busy=%0b exp 0 0", c, o_done[0], o_busy[0]);
      end
    end
    valid = 1'b0;
    fv = '{3, 3, 0, 7, 1, 1};
    run_frame(0, 0, 1'b0, "after_abort");
  endtask

  task automatic test_back_to_back();
    fv = '{6, 5, 4, 5};
    run_frame(1, 0, 1'b0, "b2b_first");
    fv = '{1, 7, 0, 2};
    run_frame(1, 0, 1'b0, "b2b_second");
    fv.delete();
    for (int i = 0; i < 255; i++) fv.push_back(7);
    fv.push_back(0);
    run_frame(2, 0, 1'b0, "full_range");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ties();
    test_gapped();
    test_abort();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mag_comp_min2_search_ctrl.md
Name: mag_comp_min2_search_ctrl

Overview:
- Sequential controller that streams one 3-bit reliability value per accepted cycle through a single strict-less-than comparison path.
- Tracks the two smallest values of a frame together with their sample indices.
- Sits between the soft-reliability source and the least-reliable-position selection logic of the BCH decoder.
- Runs one frame per start command and reports results with a done pulse.

Parameters:
- IDX_WIDTH, 8, width of sample index and internal counter.
- FRAME_LEN, 255, samples per frame. Legal range 2 to 2^IDX_WIDTH. Out-of-range values are unsupported.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rstn  input  1  asynchronous active-low reset
- i_start  input  1  begin a new frame; honoured in IDLE or DONE only
- i_abort  input  1  synchronous abort to IDLE
- i_valid  input  1  i_val carries a sample this cycle
- i_val  input  3  unsigned reliability value
- o_ready  output  1  block accepts samples; high only in RUN
- o_busy  output  1  high in RUN
- o_done  output  1  one-cycle pulse when frame results are final
- o_min1_val  output  3  smallest value of frame
- o_min1_idx  output  IDX_WIDTH  index of o_min1_val
- o_min2_val  output  3  second smallest value
- o_min2_idx  output  IDX_WIDTH  index of o_min2_val

Behaviour:
- Reset (rstn low, asynchronous):
  - State goes to IDLE; counter = 0; o_done = 0.
  - o_min1_val and o_min2_val = 3'b111.
  - o_min1_idx and o_min2_idx = all ones.
- States: IDLE, RUN, DONE. All outputs are registered.
- IDLE -> RUN on i_start. On entry: counter cleared; min registers set to reset values.
- RUN:
  - A sample is accepted when i_valid=1. Its index is the current counter value; the counter then increments.
  - i_valid=0 holds all state. There is no timeout.
  - i_start is ignored.
- Sample 0 loads min1 unconditionally (value, idx 0).
- Sample 1 with value v:
  - v < min1: min2 <= min1, min1 <= (v, 1).
  - otherwise: min2 <= (v, 1).
- Samples k >= 2 with value v:
  - v < min1: min2 <= min1, min1 <= (v, k).
  - else if v < min2: min2 <= (v, k).
  - else: no change.
- Comparison is strict unsigned less-than. On ties the earlier index is retained.
- Accepting sample FRAME_LEN-1 moves the block RUN -> DONE. o_done pulses high in the first DONE cycle, i.e. the cycle after the last sample is accepted, with final results already on the outputs.
- DONE:
  - Results are held stable; o_ready = 0; i_valid is ignored.
  - i_start starts a new frame as from IDLE. The previous results are overwritten at RUN entry.
- i_abort from any state goes to IDLE at the next edge:
  - Min registers return to reset values; o_done is not pulsed.
  - i_abort has priority over i_start and i_valid in the same cycle.
- i_start and the last i_valid can never coincide in RUN, because i_start is ignored in RUN.
- The counter never wraps within a frame; FRAME_LEN = 2^IDX_WIDTH is legal, and its last index is all ones.
- Reset asserted mid-frame: immediate return to reset values; no partial result is reported.

Test Plan:
- Reset values: assert rstn=0 during RUN -> state IDLE, o_min1/2_val=7, o_min1/2_idx=8'hFF, o_done=0, o_ready=0.
- Basic frame, FRAME_LEN=6, values 5,2,6,1,4,3 on consecutive cycles -> o_done one cycle after the 6th sample; min1=(1,3), min2=(2,1).
- Ties, FRAME_LEN=4, values 3,3,3,3 -> min1=(3,0), min2=(3,1). Also 4,2,2,0 -> min1=(0,3), min2=(2,1).
- Gapped valid and start in RUN: FRAME_LEN=4, values 7,0,7,1 with i_valid low for 2 cycles between samples and an i_start pulse mid-frame -> i_start ignored; min1=(0,1), min2=(1,3); exactly one o_done.
- Abort: i_abort after 2 of 6 samples -> IDLE, min registers back to 7/FF, no o_done. A following i_start plus a full frame completes normally.
- Back-to-back and full-range index: in DONE, i_start with i_valid in the next cycle -> new frame. FRAME_LEN=256, IDX_WIDTH=8, last sample value 0 (all others 7) -> min1=(0,8'hFF), min2=(7,0).
